// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Purpose  : Round-robin time-sharing of one four-digit hex display among four
//            requesters. Each owner keeps the display for DWELL clocks, then
//            ownership rotates to the next requester. An owner that drops its
//            request is replaced at once. The display blanks when nobody
//            requests it.
// Ports    : clk          - single clock, rising edge
//            rst_n        - asynchronous active-low reset
//            req[3:0]     - level request per requester
//            data_i[63:0] - 16-bit hex value of requester k on [16k+15:16k]
//            hold         - freezes rotation while high
//            hex_out[15:0]- value shown on the display (registered)
//            grant[3:0]   - one-hot current owner, zero when idle
//            owner[1:0]   - binary index of the current owner, zero when idle
//            blank        - high when nobody owns the display
//            switch_pulse - one-cycle strobe on every ownership change
// Revision : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int DWELL = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] data_i,
    input  logic        hold,
    output logic [15:0] hex_out,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        blank,
    output logic        switch_pulse
);

    // A one-bit counter still works for the smallest legal DWELL of 2.
    localparam int C_CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(DWELL - 1);

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_SHOW = 1'b1;

    logic [0:0]      r_state;
    logic [C_CW-1:0] r_cnt;
    logic [1:0]      r_last_ptr;
    logic [1:0]      r_owner;
    logic [3:0]      r_grant;
    logic [15:0]     r_hex;
    logic            r_blank;
    logic            r_switch;

    logic            w_found;
    logic [1:0]      w_win;
    logic [1:0]      w_cand;
    logic [15:0]     w_win_data;
    logic [15:0]     w_own_data;
    logic            w_owner_drop;
    logic            w_expire;

    // Round-robin search starting after the most recent owner. Walking the
    // candidates from farthest to nearest lets the nearest requester overwrite
    // the result, so the first hit in search order wins. The fourth
    // candidate is last_ptr itself, which lets a lone owner win again.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last_ptr;
        w_cand  = r_last_ptr;
        for (int i = 4; i >= 1; i--) begin
            w_cand = r_last_ptr + 2'(i);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_data   = data_i[{w_win, 4'b0000} +: 16];
    assign w_own_data   = data_i[{r_owner, 4'b0000} +: 16];
    assign w_owner_drop = ~req[r_owner];
    assign w_expire     = (r_cnt == C_CNT_MAX) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_IDLE;
            r_cnt      <= '0;
            r_last_ptr <= 2'd3;
            r_owner    <= 2'd0;
            r_grant    <= 4'b0000;
            r_hex      <= 16'h0000;
            r_blank    <= 1'b1;
            r_switch   <= 1'b0;
        end else begin
            r_switch <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_found) begin
                        r_state    <= C_SHOW;
                        r_owner    <= w_win;
                        r_last_ptr <= w_win;
                        r_grant    <= 4'b0001 << w_win;
                        r_hex      <= w_win_data;
                        r_blank    <= 1'b0;
                        r_cnt      <= '0;
                        r_switch   <= 1'b1;
                    end
                end
                C_SHOW: begin
                    // Owner drop is checked together with expiry; the owner
                    // can only win the search if it still requests, so a
                    // dropped owner is always replaced or the display idles.
                    if (w_owner_drop || w_expire) begin
                        r_cnt <= '0;
                        if (w_found) begin
                            r_owner    <= w_win;
                            r_last_ptr <= w_win;
                            r_grant    <= 4'b0001 << w_win;
                            r_hex      <= w_win_data;
                            r_switch   <= (w_win != r_owner);
                        end else begin
                            r_state <= C_IDLE;
                            r_owner <= 2'd0;
                            r_grant <= 4'b0000;
                            r_hex   <= 16'h0000;
                            r_blank <= 1'b1;
                        end
                    end else begin
                        r_hex <= w_own_data;
                        // Saturates at the last count while hold is high.
                        if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + C_CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign hex_out      = r_hex;
    assign grant        = r_grant;
    assign owner        = r_owner;
    assign blank        = r_blank;
    assign switch_pulse = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Purpose  : Self-checking bench for display_arbiter with DWELL=4. A table of
//            one-cycle vectors covers idle, rotation and owner drop; short
//            hand-written sequences cover single requester, hold and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int DWELL = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data_i;
    logic        hold;
    logic [15:0] hex_out;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        blank;
    logic        switch_pulse;

    int checks;
    int failures;

    display_arbiter #(.DWELL(DWELL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .data_i       (data_i),
        .hold         (hold),
        .hex_out      (hex_out),
        .grant        (grant),
        .owner        (owner),
        .blank        (blank),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic        hold;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [15:0] hex;
        logic        sw;
        logic        blank;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic [15:0] h, input logic sw, input logic b);
        chk({tag, ".grant"},  {12'h000, grant},        {12'h000, g});
        chk({tag, ".owner"},  {14'h0000, owner},       {14'h0000, o});
        chk({tag, ".hex"},    hex_out,                 h);
        chk({tag, ".switch"}, {15'h0000, switch_pulse}, {15'h0000, sw});
        chk({tag, ".blank"},  {15'h0000, blank},       {15'h0000, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic [3:0] r, input logic h,
                       input logic [3:0] g, input logic [1:0] o, input logic [15:0] x,
                       input logic sw, input logic b);
        vec_t v;
        v.name = nm; v.req = r; v.hold = h; v.grant = g; v.owner = o;
        v.hex = x; v.sw = sw; v.blank = b;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] lane0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        req      = 4'b0000;
        hold     = 1'b0;
        lane0    = 16'hA0A0;
        data_i   = {16'h3333, 16'h2222, 16'h1111, lane0};

        // Reset takes effect before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk_all("reset_async", 4'b0000, 2'd0, 16'h0000, 1'b0, 1'b1);
        tick();
        tick();
        chk_all("reset_held", 4'b0000, 2'd0, 16'h0000, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Idle, rotation between 1 and 3, owner drop, self re-win, back to idle.
        add("idle0",  4'b0000, 0, 4'b0000, 2'd0, 16'h0000, 0, 1);
        add("idle1",  4'b0000, 0, 4'b0000, 2'd0, 16'h0000, 0, 1);
        add("idle2",  4'b0000, 0, 4'b0000, 2'd0, 16'h0000, 0, 1);
        add("rr_g1",  4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 1, 0);
        add("rr_h1a", 4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 0, 0);
        add("rr_h1b", 4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 0, 0);
        add("rr_h1c", 4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 0, 0);
        add("rr_g3",  4'b1010, 0, 4'b1000, 2'd3, 16'h3333, 1, 0);
        add("rr_h3a", 4'b1010, 0, 4'b1000, 2'd3, 16'h3333, 0, 0);
        add("rr_h3b", 4'b1010, 0, 4'b1000, 2'd3, 16'h3333, 0, 0);
        add("rr_h3c", 4'b1010, 0, 4'b1000, 2'd3, 16'h3333, 0, 0);
        add("rr_back1", 4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 1, 0);
        add("rr_mid",   4'b1010, 0, 4'b0010, 2'd1, 16'h1111, 0, 0);
        add("drop_to2", 4'b0100, 0, 4'b0100, 2'd2, 16'h2222, 1, 0);
        add("d2_a",     4'b0100, 0, 4'b0100, 2'd2, 16'h2222, 0, 0);
        add("d2_b",     4'b0100, 0, 4'b0100, 2'd2, 16'h2222, 0, 0);
        add("d2_c",     4'b0100, 0, 4'b0100, 2'd2, 16'h2222, 0, 0);
        add("d2_rewin", 4'b0100, 0, 4'b0100, 2'd2, 16'h2222, 0, 0);
        add("to_idle",  4'b0000, 0, 4'b0000, 2'd0, 16'h0000, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            hold = vecs[i].hold;
            tick();
            chk_all(vecs[i].name, vecs[i].grant, vecs[i].owner, vecs[i].hex,
                    vecs[i].sw, vecs[i].blank);
        end

        // Single requester over three dwell periods; lane 0 data changes
        // part way through and must appear one edge later.
        req = 4'b0001;
        tick();
        chk_all("single_first", 4'b0001, 2'd0, lane0, 1'b1, 1'b0);
        for (int c = 1; c < 3 * DWELL; c++) begin
            if (c == 5) begin
                lane0  = 16'hBEEF;
                data_i = {16'h3333, 16'h2222, 16'h1111, lane0};
            end
            tick();
            chk_all("single_hold", 4'b0001, 2'd0, lane0, 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk_all("single_idle", 4'b0000, 2'd0, 16'h0000, 1'b0, 1'b1);

        // Hold freezes owner 1 past expiry; rotation to 0 once hold falls.
        req  = 4'b0011;
        hold = 1'b1;
        tick();
        chk_all("hold_grant", 4'b0010, 2'd1, 16'h1111, 1'b1, 1'b0);
        for (int c = 1; c < 10; c++) begin
            tick();
            chk_all("hold_frozen", 4'b0010, 2'd1, 16'h1111, 1'b0, 1'b0);
        end
        hold = 1'b0;
        tick();
        chk_all("hold_release", 4'b0001, 2'd0, lane0, 1'b1, 1'b0);

        // Owner 0 drops; requester 2 takes over, then reset strikes mid-cycle.
        req = 4'b0100;
        tick();
        chk_all("pre_reset_own2", 4'b0100, 2'd2, 16'h2222, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("mid_reset_async", 4'b0000, 2'd0, 16'h0000, 1'b0, 1'b1);
        tick();
        req   = 4'b0101;
        rst_n = 1'b1;
        tick();
        chk_all("post_reset_win0", 4'b0001, 2'd0, lane0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
